// File: rtl/rv_pkg.sv
// Shared RV fetch definitions: instruction/halfword widths, queue depth,
// fetch-port state encoding and the compressed-instruction test.
package rv_pkg;

  localparam int ILEN     = 32;
  localparam int HLEN     = 16;
  localparam int HQ_DEPTH = 3;

  localparam logic [1:0] OPC_QUAD_FULL = 2'b11;

  typedef logic [HLEN-1:0] hword_t;

  // IDLE: may request. BUSY: one fetch in flight. DROP: in-flight fetch is stale.
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_BUSY = 2'd1,
    F_DROP = 2'd2
  } fetch_state_e;

  function automatic logic is_rvc(input hword_t hw);
    return hw[1:0] != OPC_QUAD_FULL;
  endfunction

endpackage

// File: rtl/rvc_fetch_align_hword_queue.sv
// Three-entry halfword shift queue: pop 0/1/2 from the head, then append 1 or 2
// halfwords from a fetched word; flush empties it. Entry 0 is bits [15:0].
module rvc_fetch_align_hword_queue
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_vld,
  input  logic [1:0]      pop_cnt,
  input  logic            push_vld,
  input  logic            push_hi_only,
  input  logic [ILEN-1:0] push_dat,
  output logic [HLEN-1:0] hq0_dat,
  output logic [HLEN-1:0] hq1_dat,
  output logic [1:0]      cnt
);

  localparam int HQ_W = HQ_DEPTH * HLEN;

  logic [HQ_W-1:0] hq_q, hq_d;
  logic [HQ_W-1:0] shifted, keep_mask, ins_dat;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      base;

  always_comb begin
    // {idx, 4'b0000} converts a halfword index into a bit offset.
    shifted   = hq_q >> {pop_cnt, 4'b0000};
    base      = cnt_q - pop_cnt;
    keep_mask = ~({HQ_W{1'b1}} << {base, 4'b0000});
    ins_dat   = push_hi_only ? {{(HQ_W-HLEN){1'b0}}, push_dat[ILEN-1:HLEN]}
                             : {{(HQ_W-ILEN){1'b0}}, push_dat};
    hq_d  = hq_q;
    cnt_d = cnt_q;
    if (flush_vld) begin
      cnt_d = 2'd0;
    end else begin
      hq_d  = shifted;
      cnt_d = base;
      if (push_vld) begin
        hq_d  = (shifted & keep_mask) | (ins_dat << {base, 4'b0000});
        cnt_d = base + (push_hi_only ? 2'd1 : 2'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hq_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      hq_q  <= hq_d;
      cnt_q <= cnt_d;
    end
  end

  assign hq0_dat = hq_q[HLEN-1:0];
  assign hq1_dat = hq_q[2*HLEN-1:HLEN];
  assign cnt     = cnt_q;

endmodule

// File: rtl/rvc_fetch_align.sv
// Fetch aligner: word fetches into a halfword queue, one 16/32-bit instruction
// per out handshake; outputs come only from registered state, held while stalled.
module rvc_fetch_align
  import rv_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [ILEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [ILEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic            out_compressed,
  output logic [ILEN-1:0] out_pc
);

  fetch_state_e    state_q, state_d;
  logic [ILEN-1:0] out_pc_q, out_pc_d;
  logic [ILEN-1:0] fetch_addr_q, fetch_addr_d;
  logic            skip_lo_q, skip_lo_d;

  logic [HLEN-1:0] hq0, hq1;
  logic [1:0]      hq_cnt;
  logic [1:0]      pop_cnt;
  logic            hq0_rvc, fire, gnt, push_vld;

  rvc_fetch_align_hword_queue u_hq (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_vld    (redirect_valid),
    .pop_cnt      (pop_cnt),
    .push_vld     (push_vld),
    .push_hi_only (skip_lo_q),
    .push_dat     (imem_rdata),
    .hq0_dat      (hq0),
    .hq1_dat      (hq1),
    .cnt          (hq_cnt)
  );

  always_comb begin
    hq0_rvc        = is_rvc(hq0);
    out_valid      = hq0_rvc ? (hq_cnt != 2'd0) : (hq_cnt >= 2'd2);
    out_compressed = hq0_rvc;
    out_instr      = hq0_rvc ? {{HLEN{1'b0}}, hq0} : {hq1, hq0};
    out_pc         = out_pc_q;
    fire           = out_valid && out_ready && !redirect_valid;
    pop_cnt        = fire ? (hq0_rvc ? 2'd1 : 2'd2) : 2'd0;
    // Requesting only at count<=1 guarantees a full word always fits.
    imem_req       = rst_n && (state_q == F_IDLE) && (hq_cnt <= 2'd1) && !redirect_valid;
    imem_addr      = fetch_addr_q;
    gnt            = imem_req && imem_gnt;
    push_vld       = imem_rvalid && (state_q == F_BUSY) && !redirect_valid;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      F_IDLE: if (gnt) state_d = F_BUSY;
      F_BUSY: begin
        if (imem_rvalid)         state_d = F_IDLE;
        else if (redirect_valid) state_d = F_DROP;
      end
      F_DROP: if (imem_rvalid) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    out_pc_d     = out_pc_q;
    fetch_addr_d = fetch_addr_q;
    skip_lo_d    = skip_lo_q;
    if (redirect_valid) begin
      out_pc_d     = redirect_pc & ~32'h1;
      fetch_addr_d = redirect_pc & ~32'h3;
      skip_lo_d    = redirect_pc[1];
    end else begin
      if (fire)     out_pc_d     = out_pc_q + (hq0_rvc ? 32'd2 : 32'd4);
      if (gnt)      fetch_addr_d = fetch_addr_q + 32'd4;
      if (push_vld) skip_lo_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= F_IDLE;
      out_pc_q     <= RESET_PC;
      fetch_addr_q <= {RESET_PC[ILEN-1:2], 2'b00};
      skip_lo_q    <= RESET_PC[1];
    end else begin
      state_q      <= state_d;
      out_pc_q     <= out_pc_d;
      fetch_addr_q <= fetch_addr_d;
      skip_lo_q    <= skip_lo_d;
    end
  end

endmodule

// File: tb/tb_rvc_fetch_align.sv
// Bench for rvc_fetch_align: memory responder, PC-walking reference model and
// directed scenarios with literal expectations.
module tb_rvc_fetch_align;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_compressed;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  rvc_fetch_align #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_compressed (out_compressed),
    .out_pc         (out_pc)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memory image; unlisted words hold two distinct compressed halfwords.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:2], 2'b10, a[15:2], 2'b00};
  endfunction

  function automatic logic [15:0] hw_at(logic [31:0] pc);
    logic [31:0] w;
    w = mem_rd(pc & ~32'h3);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  logic [31:0] obs_pc[$];
  logic [31:0] obs_instr[$];
  logic        obs_c[$];

  // ---------------- memory responder ----------------
  int          lat = 1;
  bit          rand_mode = 1'b0;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] rsp_addr = 32'hFFFF_FFFF;
  int          grants_to_0 = 0;
  int          double_grant = 0;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_rd(pend_addr);
          rsp_addr    = pend_addr;
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      #3;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (imem_req && imem_gnt) begin
        if (pend || imem_rvalid) double_grant++;
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_cnt  = (rand_mode ? int'($urandom_range(1, 3)) : lat) - 1;
        if (imem_addr == 32'h0) grants_to_0++;
      end
    end
  end

  // ---------------- reference model / compare ----------------
  logic [31:0] exp_pc, e_instr, hold_pc, hold_instr;
  logic [15:0] e_hw;
  logic        e_c, hold_c, prev_redir, prev_stall;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_pc     = RESET_PC;
      prev_redir = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_redir) check("valid_after_redirect", {31'b0, out_valid}, 32'd0);
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_pc", out_pc, hold_pc);
        check("stall_instr", out_instr, hold_instr);
        check("stall_c", {31'b0, out_compressed}, {31'b0, hold_c});
      end
      if (imem_req) check("imem_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (out_valid && out_ready && !redirect_valid) begin
        e_hw = hw_at(exp_pc);
        e_c  = (e_hw[1:0] != 2'b11);
        e_instr = e_c ? {16'h0, e_hw} : {hw_at(exp_pc + 32'd2), e_hw};
        check("out_pc", out_pc, exp_pc);
        check("out_instr", out_instr, e_instr);
        check("out_compressed", {31'b0, out_compressed}, {31'b0, e_c});
        obs_pc.push_back(out_pc);
        obs_instr.push_back(out_instr);
        obs_c.push_back(out_compressed);
        exp_pc = exp_pc + (e_c ? 32'd2 : 32'd4);
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h1;
      prev_redir = redirect_valid;
      prev_stall = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      hold_c     = out_compressed;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; imem_gnt = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    obs_pc.delete(); obs_instr.delete(); obs_c.delete();
    @(negedge clk);
    rst_n = 1'b1;
    grants_to_0 = 0;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC & ~32'h3);
  endtask

  task automatic wait_obs(int n, int budget);
    int k = 0;
    while (obs_pc.size() < n && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    if (obs_pc.size() < n) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_outputs: got %0d outputs, required %0d", obs_pc.size(), n);
    end
  endtask

  task automatic expect_obs(string nm, int idx, logic [31:0] pc, logic [31:0] instr, logic c);
    if (idx < obs_pc.size()) begin
      check({nm, "_pc"}, obs_pc[idx], pc);
      check({nm, "_instr"}, obs_instr[idx], instr);
      check({nm, "_c"}, {31'b0, obs_c[idx]}, {31'b0, c});
    end else begin
      tests_run++; tests_failed++;
      $display("FAIL %s: output %0d missing, got %0d outputs", nm, idx, obs_pc.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int stalls;
    int n0;
    int hits;
    bit found;

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b1; out_ready = 1'b1;

    // Two full-width instructions.
    mem.delete();
    mem[32'h0] = 32'h0050_0093; mem[32'h4] = 32'h00A0_0113;
    do_reset();
    wait_obs(2, 60);
    expect_obs("t1_a", 0, 32'h0, 32'h0050_0093, 1'b0);
    expect_obs("t1_b", 1, 32'h4, 32'h00A0_0113, 1'b0);

    // Two compressed from one word, fetched once.
    mem.delete();
    mem[32'h0] = 32'h4505_0505;
    do_reset();
    wait_obs(2, 60);
    expect_obs("t2_a", 0, 32'h0, 32'h0000_0505, 1'b1);
    expect_obs("t2_b", 1, 32'h2, 32'h0000_4505, 1'b1);
    check("t2_fetch0_once", grants_to_0, 32'd1);

    // Straddling 32-bit instruction.
    mem.delete();
    mem[32'h0] = 32'h0093_0505; mem[32'h4] = 32'h0505_0050;
    do_reset();
    wait_obs(3, 60);
    expect_obs("t3_a", 0, 32'h0, 32'h0000_0505, 1'b1);
    expect_obs("t3_b", 1, 32'h2, 32'h0050_0093, 1'b0);
    expect_obs("t3_c", 2, 32'h6, 32'h0000_0505, 1'b1);

    // Redirect to an odd halfword drops the lower half.
    mem.delete();
    mem[32'h100] = 32'h4505_0001;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("t4_req", {31'b0, imem_req}, 32'd1);
    check("t4_addr", imem_addr, 32'h0000_0100);
    wait_obs(3, 60);
    expect_obs("t4_a", 0, 32'h102, 32'h0000_4505, 1'b1);

    // Stall with a full queue.
    mem.delete();
    mem[32'h0] = 32'h0093_0505; mem[32'h4] = 32'h0505_0050;
    do_reset();
    wait_obs(1, 60);
    stalls = 0;
    repeat (7) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      if (out_valid) begin
        stalls++;
        check("t5_no_req", {31'b0, imem_req}, 32'd0);
      end
    end
    check("t5_stall_cycles", stalls, 32'd5);
    @(negedge clk);
    out_ready = 1'b1;
    wait_obs(3, 40);
    expect_obs("t5_b", 1, 32'h2, 32'h0050_0093, 1'b0);
    expect_obs("t5_c", 2, 32'h6, 32'h0000_0505, 1'b1);

    // Redirect in the cycle the response for 0x8 returns.
    mem.delete();
    mem[32'h0] = 32'h0050_0093; mem[32'h4] = 32'h00A0_0113; mem[32'h8] = 32'h00F0_0193;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      #1;
      if (imem_rvalid && rsp_addr == 32'h8) found = 1'b1;
    end
    check("t6_saw_resp8", {31'b0, found}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    n0 = obs_pc.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_obs(n0 + 1, 40);
    expect_obs("t6_next", n0, 32'h40, 32'h0000_0040, 1'b1);
    hits = 0;
    foreach (obs_pc[i]) if (obs_pc[i] == 32'h8) hits++;
    check("t6_mem8_dropped", hits, 32'd0);

    // Redirect while a slow fetch is in flight.
    mem.delete();
    lat = 3;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #1;
      if (pend) found = 1'b1;
    end
    check("t7_pending", {31'b0, found}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("t7_req_wait1", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    check("t7_req_wait2", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    check("t7_req_after_drop", {31'b0, imem_req}, 32'd1);
    check("t7_addr", imem_addr, 32'h0000_0080);
    wait_obs(1, 40);
    expect_obs("t7_a", 0, 32'h80, 32'h0000_0080, 1'b1);
    lat = 1;

    // Random words, random backpressure/grant/latency and redirects.
    mem.delete();
    for (int i = 0; i < 32; i++) mem[32'h200 + 32'(4 * i)] = $urandom;
    do_reset();
    rand_mode = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      out_ready      = ($urandom % 4) != 0;
      imem_gnt       = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 32) == 0;
      redirect_pc    = 32'h200 + 32'($urandom_range(0, 60) * 2) + 32'($urandom % 2);
    end
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1; imem_gnt = 1'b1;
    rand_mode = 1'b0;
    repeat (20) @(negedge clk);
    check("t8_progress", {31'b0, obs_pc.size() >= 40}, 32'd1);
    check("single_outstanding", double_grant, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
